zipdbg_master: RTL and testbench

ZIPDBG_MASTER -- requirements
Module: zipdbg_master

---
 rtl/zipdbg_pkg.sv | 57 +++++
 rtl/zipdbg_master_timeout.sv | 25 ++
 rtl/zipdbg_master.sv | 144 ++++++++++++++
 tb/tb_zipdbg_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zipdbg_pkg.sv
// Shared types for the ZipCPU debug-port Wishbone master:
// opcodes, FSM states and control-word bit positions.
package zipdbg_pkg;

    typedef enum logic [2:0] {
        OP_READ_REG  = 3'd0,
        OP_WRITE_REG = 3'd1,
        OP_HALT      = 3'd2,
        OP_RELEASE   = 3'd3,
        OP_STEP      = 3'd4,
        OP_RESET     = 3'd5,
        OP_STATUS    = 3'd6,
        OP_CLR_CACHE = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CTL     = 3'd1,
        S_CTL_ACK = 3'd2,
        S_DAT     = 3'd3,
        S_DAT_ACK = 3'd4,
        S_RSP     = 3'd5
    } state_e;

    localparam int CW_RESET = 6;
    localparam int CW_STEP  = 8;
    localparam int CW_HALT  = 10;
    localparam int CW_CLR   = 11;

    function automatic logic [31:0] ctl_word(
        input op_e        op,
        input logic [4:0] rg,
        input logic       halted
    );
        logic [31:0] w;
        w = '0;
        case (op)
            OP_READ_REG, OP_WRITE_REG: begin
                w[CW_HALT] = 1'b1;
                w[4:0]     = rg;
            end
            OP_HALT:    w[CW_HALT] = 1'b1;
            OP_RELEASE: w = '0;
            OP_STEP:    w[CW_STEP] = 1'b1;
            OP_RESET: begin
                w[CW_RESET] = 1'b1;
                w[CW_HALT]  = halted;
            end
            default: begin
                w[CW_HALT] = halted;
                w[CW_CLR]  = (op == OP_CLR_CACHE);
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/zipdbg_master_timeout.sv
// Bus-phase watchdog: counts while run is high, zeroed on restart;
// expired flags the TIMEOUT-th counted cycle.
module zipdbg_timeout #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    input  logic i_run,
    output logic o_expired
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart)
            r_cnt <= '0;
        else if (i_run)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = i_run && (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/zipdbg_master.sv
// Command-driven Wishbone master for the ZipCPU debug port:
// control-word write, optional data-register access, one response.
module zipdbg_master
    import zipdbg_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [2:0]  i_cmd_op,
    input  logic [4:0]  i_cmd_reg,
    input  logic [31:0] i_cmd_data,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_dbg_cyc,
    output logic        o_dbg_stb,
    output logic        o_dbg_we,
    output logic        o_dbg_addr,
    output logic [31:0] o_dbg_data,
    input  logic        i_dbg_ack,
    input  logic        i_dbg_stall,
    input  logic [31:0] i_dbg_data
);
    state_e      r_state, w_next;
    op_e         r_op;
    logic [4:0]  r_reg;
    logic [31:0] r_data;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic        r_halted;
    logic        w_abort;
    logic        w_run;
    logic        w_restart;
    logic        w_expired;
    logic        w_has_dat;

    assign w_has_dat = (r_op == OP_READ_REG) || (r_op == OP_WRITE_REG);

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        case (r_state)
            S_IDLE:
                if (i_cmd_valid) w_next = S_CTL;
            S_CTL:
                if (!i_dbg_stall) w_next = S_CTL_ACK;
                else if (w_expired) w_abort = 1'b1;
            S_CTL_ACK:
                if (i_dbg_ack) w_next = w_has_dat ? S_DAT : S_RSP;
                else if (w_expired) w_abort = 1'b1;
            S_DAT:
                if (!i_dbg_stall) w_next = S_DAT_ACK;
                else if (w_expired) w_abort = 1'b1;
            S_DAT_ACK:
                if (i_dbg_ack) w_next = S_RSP;
                else if (w_expired) w_abort = 1'b1;
            S_RSP:
                if (i_rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_RSP;
    end

    // Every phase change gives the next phase a fresh timeout budget.
    assign w_restart = (w_next != r_state);
    assign w_run = (((r_state == S_CTL) || (r_state == S_DAT)) && i_dbg_stall)
                 || (r_state == S_CTL_ACK) || (r_state == S_DAT_ACK);

    zipdbg_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (w_restart),
        .i_run     (w_run),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_READ_REG;
            r_reg      <= '0;
            r_data     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_cmd_valid) begin
                r_op   <= op_e'(i_cmd_op);
                r_reg  <= i_cmd_reg;
                r_data <= i_cmd_data;
            end
            if (r_state == S_CTL_ACK && i_dbg_ack) begin
                if (w_has_dat || r_op == OP_HALT || r_op == OP_STEP)
                    r_halted <= 1'b1;
                else if (r_op == OP_RELEASE)
                    r_halted <= 1'b0;
                if (!w_has_dat) begin
                    r_rsp_data <= i_dbg_data;
                    r_rsp_err  <= 1'b0;
                end
            end
            if (r_state == S_DAT_ACK && i_dbg_ack) begin
                r_rsp_data <= i_dbg_data;
                r_rsp_err  <= 1'b0;
            end
            if (w_abort) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
            if (r_state == S_RSP && i_rsp_ready)
                r_rsp_err <= 1'b0;
        end
    end

    always_comb begin
        o_dbg_stb  = 1'b0;
        o_dbg_we   = 1'b0;
        o_dbg_addr = 1'b0;
        o_dbg_data = '0;
        o_dbg_cyc  = (r_state == S_CTL) || (r_state == S_CTL_ACK)
                  || (r_state == S_DAT) || (r_state == S_DAT_ACK);
        if (r_state == S_CTL) begin
            o_dbg_stb  = 1'b1;
            o_dbg_we   = 1'b1;
            o_dbg_data = ctl_word(r_op, r_reg, r_halted);
        end else if (r_state == S_DAT) begin
            o_dbg_stb  = 1'b1;
            o_dbg_we   = (r_op == OP_WRITE_REG);
            o_dbg_addr = 1'b1;
            o_dbg_data = r_data;
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_rsp_valid = (r_state == S_RSP);
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_zipdbg_master.sv
// Directed bench for zipdbg_master: vector table with a reactive
// slave model, plus hand sequences for reset and spurious acks.
module tb_zipdbg_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_reg;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        dbg_cyc, dbg_stb, dbg_we, dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack, dbg_stall;
    logic [31:0] dbg_rdata;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    zipdbg_master #(.TIMEOUT(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_reg   (cmd_reg),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_dbg_cyc   (dbg_cyc),
        .o_dbg_stb   (dbg_stb),
        .o_dbg_we    (dbg_we),
        .o_dbg_addr  (dbg_addr),
        .o_dbg_data  (dbg_wdata),
        .i_dbg_ack   (dbg_ack),
        .i_dbg_stall (dbg_stall),
        .i_dbg_data  (dbg_rdata)
    );

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rg;
        logic [31:0] d;
        int          cst;
        int          dst;
        bit          noack;
        logic [31:0] cd;
        logic [31:0] dd;
        logic [31:0] ew;
        int          ectl;
        bit          edat;
        bit          ewe;
        int          edatn;
        int          ewait;
        logic [31:0] ersp;
        bit          eerr;
        int          hold;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic [2:0] op, input logic [4:0] rg, input logic [31:0] d,
        input int cst, input int dst, input bit noack,
        input logic [31:0] cd, input logic [31:0] dd, input logic [31:0] ew,
        input int ectl, input bit edat, input bit ewe, input int edatn,
        input int ewait, input logic [31:0] ersp, input bit eerr, input int hold
    );
        vec_t v;
        v.op = op; v.rg = rg; v.d = d; v.cst = cst; v.dst = dst;
        v.noack = noack; v.cd = cd; v.dd = dd; v.ew = ew; v.ectl = ectl;
        v.edat = edat; v.ewe = ewe; v.edatn = edatn; v.ewait = ewait;
        v.ersp = ersp; v.eerr = eerr; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] ctl_w;
        logic [31:0] dat_w;
        logic [31:0] held;
        bit          dat_we;
        bit          dat_seen;
        bit          ack_now;
        bit          ack_next;
        int          ctl_n, dat_n, waits, cst, dst;
        string       p;
        p = $sformatf("v%0d", idx);
        ctl_w = '0; dat_w = '0; dat_we = 0; dat_seen = 0;
        ack_next = 0; ctl_n = 0; dat_n = 0; waits = 0;
        cst = v.cst; dst = v.dst;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_reg   = v.rg;
        cmd_data  = v.d;
        chk({p, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        cmd_data  = 32'h0;
        cmd_reg   = 5'h0;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid) break;
            ack_now  = ack_next;
            ack_next = 0;
            dbg_stall = 1'b0;
            if (dbg_cyc && !dbg_stb) waits++;
            if (dbg_stb && !dbg_addr) begin
                ctl_n++;
                ctl_w = dbg_wdata;
                if (cst > 0) begin
                    cst--;
                    dbg_stall = 1'b1;
                end else begin
                    ack_next = !v.noack;
                end
            end else if (dbg_stb && dbg_addr) begin
                dat_n++;
                dat_seen = 1;
                dat_w = dbg_wdata;
                dat_we = dbg_we;
                if (dst > 0) begin
                    dst--;
                    dbg_stall = 1'b1;
                end else begin
                    ack_next = !v.noack;
                end
            end
            dbg_ack   = ack_now;
            dbg_rdata = !ack_now ? 32'hBAD0BAD0 : (dat_seen ? v.dd : v.cd);
            step();
        end
        dbg_ack = 1'b0;
        dbg_stall = 1'b0;
        dbg_rdata = 32'hBAD0BAD0;
        chk({p, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({p, " cyc_dropped"}, 32'(dbg_cyc), 32'd0);
        chk({p, " ctl_word"}, ctl_w, v.ew);
        chk({p, " ctl_stb_cycles"}, 32'(ctl_n), 32'(v.ectl));
        chk({p, " dat_phase"}, 32'(dat_seen), 32'(v.edat));
        if (v.edat) begin
            chk({p, " dat_we"}, 32'(dat_we), 32'(v.ewe));
            chk({p, " dat_wdata"}, dat_w, v.d);
            chk({p, " dat_stb_cycles"}, 32'(dat_n), 32'(v.edatn));
        end
        chk({p, " ack_wait_cycles"}, 32'(waits), 32'(v.ewait));
        chk({p, " rsp_data"}, rsp_data, v.ersp);
        chk({p, " rsp_err"}, 32'(rsp_err), 32'(v.eerr));
        held = rsp_data;
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk({p, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({p, " hold data"}, rsp_data, held);
            chk({p, " hold ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({p, " rsp_taken"}, 32'(rsp_valid), 32'd0);
        chk({p, " err_cleared"}, 32'(rsp_err), 32'd0);
        chk({p, " idle_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = mk(6, 0,  0, 0, 0, 0, 32'hC0DE0000, 0, 32'h000, 1, 0, 0, 0, 1, 32'hC0DE0000, 0, 0);
        vecs[1]  = mk(0, 3,  32'h0BADF00D, 0, 0, 0, 32'hAAAA0001, 32'h12345678, 32'h403, 1, 1, 0, 1, 2, 32'h12345678, 0, 3);
        vecs[2]  = mk(1, 5,  32'hDEADBEEF, 0, 4, 0, 32'hAAAA0002, 32'h55, 32'h405, 1, 1, 1, 5, 2, 32'h55, 0, 0);
        vecs[3]  = mk(3, 0,  0, 0, 0, 0, 32'h11110003, 0, 32'h000, 1, 0, 0, 0, 1, 32'h11110003, 0, 0);
        vecs[4]  = mk(4, 0,  0, 2, 0, 0, 32'h22220004, 0, 32'h100, 3, 0, 0, 0, 1, 32'h22220004, 0, 0);
        vecs[5]  = mk(6, 0,  0, 0, 0, 0, 32'h5A5A0006, 0, 32'h400, 1, 0, 0, 0, 1, 32'h5A5A0006, 0, 3);
        vecs[6]  = mk(7, 0,  0, 0, 0, 0, 32'h77770007, 0, 32'hC00, 1, 0, 0, 0, 1, 32'h77770007, 0, 0);
        vecs[7]  = mk(5, 0,  0, 0, 0, 0, 32'h55550005, 0, 32'h440, 1, 0, 0, 0, 1, 32'h55550005, 0, 0);
        vecs[8]  = mk(2, 0,  0, 0, 0, 0, 32'h33330002, 0, 32'h400, 1, 0, 0, 0, 1, 32'h33330002, 0, 0);
        vecs[9]  = mk(0, 31, 0, 0, 0, 1, 32'h99990000, 0, 32'h41F, 1, 0, 0, 0, 8, 32'h0, 1, 3);
        vecs[10] = mk(3, 0,  0, 0, 0, 0, 32'h44440003, 0, 32'h000, 1, 0, 0, 0, 1, 32'h44440003, 0, 0);
        vecs[11] = mk(5, 0,  0, 0, 0, 0, 32'h66660005, 0, 32'h040, 1, 0, 0, 0, 1, 32'h66660005, 0, 0);
        vecs[12] = mk(2, 0,  0, 20, 0, 0, 32'h0, 0, 32'h400, 8, 0, 0, 0, 0, 32'h0, 1, 0);

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_reg = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        dbg_ack = 1'b0; dbg_stall = 1'b0; dbg_rdata = 32'hBAD0BAD0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset cyc", 32'(dbg_cyc), 32'd0);
        chk("reset stb", 32'(dbg_stb), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        dbg_ack = 1'b1;
        dbg_rdata = 32'hFFFF0000;
        step();
        dbg_ack = 1'b0;
        chk("idle ack ignored ready", 32'(cmd_ready), 32'd1);
        chk("idle ack ignored rsp", 32'(rsp_valid), 32'd0);

        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_reg = 5'd7; cmd_data = 32'h0;
        step();
        cmd_valid = 1'b0;
        chk("rstseq ctl stb", 32'({dbg_stb, dbg_addr}), 32'd2);
        step();
        dbg_ack = 1'b1; dbg_rdata = 32'h1;
        step();
        dbg_ack = 1'b0;
        chk("rstseq dat stb", 32'({dbg_stb, dbg_addr}), 32'd3);
        step();
        chk("rstseq dat_ack cyc", 32'({dbg_cyc, dbg_stb}), 32'd2);
        rst = 1'b1; dbg_ack = 1'b1; dbg_rdata = 32'hCAFEF00D;
        step();
        rst = 1'b0; dbg_ack = 1'b0;
        chk("rstseq cyc", 32'(dbg_cyc), 32'd0);
        chk("rstseq cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstseq rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstseq rsp_data", rsp_data, 32'd0);
        step();
        chk("rstseq no rsp later", 32'(rsp_valid), 32'd0);

        run_vec(13, mk(6, 0, 0, 0, 0, 0, 32'h0D0D0006, 0, 32'h000, 1, 0, 0, 0, 1, 32'h0D0D0006, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
